// File: rtl/decoder_pkg.sv
// decoder_pkg: mode encodings and one-hot helpers shared by the decoder_scan block.
// Pure constants/functions; no latency, no flow control.
package decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest supported address; onehot() is sized for it and callers truncate.
   localparam int MAX_ADDR_W = 8;
   localparam int ONEHOT_MAX = 1 << MAX_ADDR_W;

   function automatic int nout(input int aw);
      return 1 << aw;
   endfunction

   function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [MAX_ADDR_W-1:0] i);
      logic [ONEHOT_MAX-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/decoder_scan_prescaler.sv
// scan_prescaler: counts 0..div, tick while cnt >= div; clear wins over enable.
// Tick is combinational from the registered count; no backpressure, holds when disabled.
module scan_prescaler #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;

   // >= rather than == so a div lowered below the running count steps immediately.
   assign o_tick = i_en && (r_cnt >= i_div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tick ? '0 : r_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder with round-robin auto-scan, 1-cycle latency.
// No backpressure; enable=0 blanks outputs and freezes scan. Optional DECODER_SCAN_BLANK_EN adds step dead time.
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int ADDR_W = 2,
   parameter int DIV_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    mode,
   input  logic [ADDR_W-1:0]       address,
   input  logic [DIV_W-1:0]        div,
   output logic [nout(ADDR_W)-1:0] out,
   output logic [ADDR_W-1:0]       idx,
   output logic                    wrap
);

   localparam int NOUT = nout(ADDR_W);

   logic              r_en_q;
   logic [ADDR_W-1:0] r_idx;
   logic [NOUT-1:0]   r_out;
   logic              r_wrap;

   logic              w_tick;
   logic              w_scan_run;
   logic              w_clr;
   logic              w_blank;
   logic              w_wrap_nxt;
   logic [ADDR_W-1:0] w_idx_nxt;
   logic [NOUT-1:0]   w_out_nxt;

   // Scan stepping waits one cycle after re-enable so the held index is shown before moving on.
   assign w_scan_run = enable && (mode == MODE_SCAN) && r_en_q;
   assign w_clr      = enable && (mode == MODE_DIRECT);

   scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_en   (w_scan_run),
      .i_div  (div),
      .o_tick (w_tick)
   );

`ifdef DECODER_SCAN_BLANK_EN
   assign w_blank = w_tick && (div != '0);
`else
   assign w_blank = 1'b0;
`endif

   assign w_wrap_nxt = w_tick && (r_idx == ADDR_W'(NOUT - 1));

   always_comb begin
      w_idx_nxt = r_idx;
      if (enable) begin
         if (mode == MODE_DIRECT) begin
            w_idx_nxt = address;
         end else if (w_tick) begin
            w_idx_nxt = r_idx + ADDR_W'(1);
         end
      end
      w_out_nxt = '0;
      if (enable && !w_blank) begin
         w_out_nxt = NOUT'(onehot(MAX_ADDR_W'(w_idx_nxt)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_q <= 1'b0;
         r_idx  <= '0;
         r_out  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_en_q <= enable;
         r_idx  <= w_idx_nxt;
         r_out  <= w_out_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign out  = r_out;
   assign idx  = r_idx;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan (ADDR_W=2, DIV_W=8); expected values are hand-derived tables.
module tb_decoder_scan;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       mode;
   logic [1:0] address;
   logic [7:0] div;
   logic [3:0] out;
   logic [1:0] idx;
   logic       wrap;

   int n_checks = 0;
   int n_errors = 0;

   decoder_scan #(.ADDR_W(2), .DIV_W(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .mode    (mode),
      .address (address),
      .div     (div),
      .out     (out),
      .idx     (idx),
      .wrap    (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int t3_idx [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
   int t6_idx [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 3, 0, 1, 2};
`ifdef DECODER_SCAN_BLANK_EN
   int t6_out [12] = '{1, 1, 1, 0, 2, 2, 2, 0, 8, 1, 2, 4};
`else
   int t6_out [12] = '{1, 1, 1, 2, 2, 2, 2, 4, 8, 1, 2, 4};
`endif

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b0;
      mode    = 1'b0;
      address = 2'd0;
      div     = 8'd0;
      #12;
      chk("rst_out", int'(out), 0);
      chk("rst_idx", int'(idx), 0);
      chk("rst_wrap", int'(wrap), 0);
      rst_n = 1'b1;

      // 1: direct decode, one edge of latency
      enable = 1'b1;
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         if (a > 0) chk("dir_latency", int'(out), 1 << (a - 1));
         step();
         chk("dir_out", int'(out), 1 << a);
         chk("dir_idx", int'(idx), a);
         step();
         chk("dir_hold", int'(out), 1 << a);
         chk("dir_wrap", int'(wrap), 0);
      end

      // 2: enable gating
      enable = 1'b0;
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         step();
         chk("gate_out", int'(out), 0);
         chk("gate_idx", int'(idx), 3);
      end
      enable  = 1'b1;
      address = 2'd2;
      step();
      chk("reen_out", int'(out), 4);
      chk("reen_idx", int'(idx), 2);

      // 3: scan with div=2, address ignored
      address = 2'd0;
      step();
      mode    = 1'b1;
      div     = 8'd2;
      address = 2'd3;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("scan_idx", int'(idx), t3_idx[i]);
         chk("scan_out", int'(out), 1 << t3_idx[i]);
         chk("scan_wrap", int'(wrap), (i == 11) ? 1 : 0);
      end

      // 4: div=0 steps every cycle, then freeze
      div = 8'd0;
      step();
      chk("fast_idx1", int'(idx), 1);
      chk("fast_wrap", int'(wrap), 0);
      step();
      chk("fast_idx2", int'(idx), 2);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("frz_out", int'(out), 0);
         chk("frz_idx", int'(idx), 2);
         chk("frz_wrap", int'(wrap), 0);
      end
      enable = 1'b1;
      step();
      chk("resume_out", int'(out), 4);
      chk("resume_idx", int'(idx), 2);
      step();
      chk("resume_out3", int'(out), 8);
      step();
      chk("resume_idx0", int'(idx), 0);
      chk("resume_wrap", int'(wrap), 1);

      // 5: div shrink, mode 1->0, async reset mid-scan
      div = 8'd10;
      for (int i = 0; i < 6; i++) step();
      chk("long_idx", int'(idx), 0);
      chk("long_wrap", int'(wrap), 0);
      div = 8'd3;
      step();
      chk("shrink_idx", int'(idx), 1);
      chk("shrink_out", int'(out), 2);
      mode    = 1'b0;
      address = 2'd3;
      step();
      chk("m10_idx", int'(idx), 3);
      chk("m10_out", int'(out), 8);
      mode = 1'b1;
      div  = 8'd10;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out", int'(out), 0);
      chk("arst_idx", int'(idx), 0);
      chk("arst_wrap", int'(wrap), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 6: div=3 step pattern (blanked first cycle when DECODER_SCAN_BLANK_EN), then div=0
      enable  = 1'b1;
      mode    = 1'b0;
      address = 2'd0;
      div     = 8'd3;
      step();
      chk("t6_start", int'(out), 1);
      mode = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 8) div = 8'd0;
         step();
         chk("t6_idx", int'(idx), t6_idx[i]);
         chk("t6_out", int'(out), t6_out[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
